// File: rtl/ps2_ascii_sender.sv
// Device-side PS/2 keyboard emulator: maps one ASCII character to its Set-2 scan code
// and drives a make / 0xF0 / break keystroke onto the PS/2 clock and data lines.
module ps2_ascii_sender #(
  parameter int unsigned CLK_HALF   = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       unmapped
);

  localparam int unsigned CW = $clog2(CLK_HALF) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [CW-1:0] HalfLast = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] BitLast  = CW'(2 * CLK_HALF - 1);
  localparam logic [GW-1:0] GapLast  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e        state_q;
  logic [7:0]    code_q;
  logic [1:0]    byte_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] gap_q;
  logic          ps2_clk_q;
  logic          ps2_data_q;
  logic          unmapped_q;

  // Returns {hit, scan_code}; lowercase letters fold onto uppercase.
  function automatic logic [8:0] ascii_to_scan(input logic [7:0] ch);
    logic [7:0] c;
    c = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
    case (c)
      "0": return 9'h145;  "1": return 9'h116;  "2": return 9'h11e;  "3": return 9'h126;
      "4": return 9'h125;  "5": return 9'h12e;  "6": return 9'h136;  "7": return 9'h13d;
      "8": return 9'h13e;  "9": return 9'h146;
      "A": return 9'h11c;  "B": return 9'h132;  "C": return 9'h121;  "D": return 9'h123;
      "E": return 9'h124;  "F": return 9'h12b;  "G": return 9'h134;  "H": return 9'h133;
      "I": return 9'h143;  "J": return 9'h13b;  "K": return 9'h142;  "L": return 9'h14b;
      "M": return 9'h13a;  "N": return 9'h131;  "O": return 9'h144;  "P": return 9'h14d;
      "Q": return 9'h115;  "R": return 9'h12d;  "S": return 9'h11b;  "T": return 9'h12c;
      "U": return 9'h13c;  "V": return 9'h12a;  "W": return 9'h11d;  "X": return 9'h122;
      "Y": return 9'h135;  "Z": return 9'h11a;
      8'h20: return 9'h129;  8'h60: return 9'h10e;  8'h2d: return 9'h14e;
      8'h3d: return 9'h155;  8'h5b: return 9'h154;  8'h5d: return 9'h15b;
      8'h5c: return 9'h15d;  8'h3b: return 9'h14c;  8'h27: return 9'h152;
      8'h2c: return 9'h141;  8'h2e: return 9'h149;
      default: return 9'h000;
    endcase
  endfunction

  logic [8:0]  map;
  logic [7:0]  cur_byte;
  logic [10:0] frame;

  always_comb begin
    map      = ascii_to_scan(ascii_in);
    cur_byte = (byte_q == 2'd1) ? 8'hf0 : code_q;
    frame    = {1'b1, ~^cur_byte, cur_byte, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      code_q     <= 8'h00;
      byte_q     <= 2'd0;
      bit_q      <= 4'd0;
      cnt_q      <= '0;
      gap_q      <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      unmapped_q <= 1'b0;
    end else begin
      unmapped_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ascii_valid) begin
            if (map[8]) begin
              code_q     <= map[7:0];
              state_q    <= StSend;
              byte_q     <= 2'd0;
              bit_q      <= 4'd0;
              cnt_q      <= '0;
              ps2_clk_q  <= 1'b1;
              ps2_data_q <= 1'b0;
            end else begin
              unmapped_q <= 1'b1;
            end
          end
        end
        StSend: begin
          if (cnt_q == HalfLast) ps2_clk_q <= 1'b0;
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            ps2_clk_q <= 1'b1;
            if (bit_q == 4'd10) begin
              state_q    <= StGap;
              ps2_data_q <= 1'b1;
              gap_q      <= '0;
            end else begin
              // Next bit goes out at the start of its high phase.
              bit_q      <= bit_q + 4'd1;
              ps2_data_q <= frame[bit_q + 4'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            gap_q <= '0;
            if (byte_q == 2'd2) begin
              state_q <= StIdle;
              byte_q  <= 2'd0;
            end else begin
              state_q    <= StSend;
              byte_q     <= byte_q + 2'd1;
              bit_q      <= 4'd0;
              cnt_q      <= '0;
              ps2_data_q <= 1'b0;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ascii_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign ps2_clk     = ps2_clk_q;
  assign ps2_data    = ps2_data_q;
  assign unmapped    = unmapped_q;

endmodule

// File: tb/tb_ps2_ascii_sender.sv
// Scoreboard bench: expected scan-code bytes are queued at accept and compared against
// frames decoded from the PS/2 lines at each falling ps2_clk.
module tb_ps2_ascii_sender;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] ascii_in = 8'h00, ascii_in_f = 8'h00;
  logic       ascii_valid = 1'b0, ascii_valid_f = 1'b0;
  logic       ascii_ready, ps2_clk, ps2_data, busy, unmapped;
  logic       ascii_ready_f, ps2_clk_f, ps2_data_f, busy_f, unmapped_f;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;

  ps2_ascii_sender dut (
    .clk(clk), .rst_n(rst_n), .ascii_in(ascii_in), .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .unmapped(unmapped)
  );

  ps2_ascii_sender #(.CLK_HALF(1), .GAP_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .ascii_in(ascii_in_f), .ascii_valid(ascii_valid_f),
    .ascii_ready(ascii_ready_f), .ps2_clk(ps2_clk_f), .ps2_data(ps2_data_f),
    .busy(busy_f), .unmapped(unmapped_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_key(input int id, input logic [7:0] code);
    if (id == 0) begin
      exp_q0.push_back(code); exp_q0.push_back(8'hf0); exp_q0.push_back(code);
    end else begin
      exp_q1.push_back(code); exp_q1.push_back(8'hf0); exp_q1.push_back(code);
    end
  endtask

  task automatic got_frame(input int id, input logic [10:0] f);
    logic [7:0] e;
    if (id == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
    else if (id == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    else begin
      check("unexpected_frame", {21'd0, f}, 32'd0);
      return;
    end
    check(id == 0 ? "frame" : "frame_fast", {21'd0, f}, {21'd0, 1'b1, ~^e, e, 1'b0});
  endtask

  // Frame decoder: host samples data on each falling ps2_clk.
  logic [10:0] sh[2];
  int          nb[2];
  logic        pc[2];
  initial begin
    pc[0] = 1'b1; pc[1] = 1'b1; nb[0] = 0; nb[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic c, d;
        c = (i == 0) ? ps2_clk : ps2_clk_f;
        d = (i == 0) ? ps2_data : ps2_data_f;
        if (!rst_n) begin
          nb[i] = 0;
          pc[i] = 1'b1;
        end else begin
          if (pc[i] && !c) begin
            sh[i] = {d, sh[i][10:1]};
            nb[i]++;
            if (nb[i] == 11) begin
              got_frame(i, sh[i]);
              nb[i] = 0;
            end
          end
          pc[i] = c;
        end
      end
    end
  end

  function automatic logic rdy(input int id);
    return (id == 0) ? ascii_ready : ascii_ready_f;
  endfunction

  // Drives one mapped character, accepts it on the next edge and times the keystroke.
  task automatic send_key(input int id, input logic [7:0] ch, input logic [7:0] code,
                          input int exp_cycles);
    int n;
    push_key(id, code);
    if (id == 0) begin ascii_in = ch; ascii_valid = 1'b1; end
    else begin ascii_in_f = ch; ascii_valid_f = 1'b1; end
    @(posedge clk); #1;
    ascii_valid = 1'b0; ascii_valid_f = 1'b0; ascii_in = 8'h00; ascii_in_f = 8'h00;
    check("ready_low_after_accept", {31'd0, rdy(id)}, 32'd0);
    check("busy_after_accept", {31'd0, (id == 0) ? busy : busy_f}, 32'd1);
    check("no_unmapped_pulse", {31'd0, (id == 0) ? unmapped : unmapped_f}, 32'd0);
    n = 0;
    while (!rdy(id) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("keystroke_cycles", n, exp_cycles);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
    check("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
    check("rst_ready", {31'd0, ascii_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_unmapped", {31'd0, unmapped}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic keystrokes and case folding.
    send_key(0, 8'h41, 8'h1c, 312);
    send_key(0, 8'h61, 8'h1c, 312);
    send_key(0, 8'h30, 8'h45, 312);

    // Unmapped character, then an immediate mapped one.
    ascii_in = 8'h21; ascii_valid = 1'b1;
    @(posedge clk); #1;
    check("unmapped_pulse", {31'd0, unmapped}, 32'd1);
    check("unmapped_ready", {31'd0, ascii_ready}, 32'd1);
    check("unmapped_busy", {31'd0, busy}, 32'd0);
    check("unmapped_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    send_key(0, 8'h20, 8'h29, 312);

    // Back-to-back with valid held high.
    push_key(0, 8'h33);
    push_key(0, 8'h43);
    ascii_in = 8'h48; ascii_valid = 1'b1;
    @(posedge clk); #1;
    ascii_in = 8'h49;
    check("hi_busy_h", {31'd0, busy}, 32'd1);
    n = 0;
    while (!ascii_ready && n < 2000) begin @(posedge clk); #1; n++; end
    check("hi_h_cycles", n, 312);
    @(posedge clk); #1;
    ascii_valid = 1'b0; ascii_in = 8'h00;
    check("hi_i_accepted_first_ready", {31'd0, busy}, 32'd1);
    n = 0;
    while (!ascii_ready && n < 2000) begin @(posedge clk); #1; n++; end
    check("hi_i_cycles", n, 312);

    // Reset during bit 4 of the F0 frame.
    push_key(0, 8'h42);
    ascii_in = 8'h4b; ascii_valid = 1'b1;
    @(posedge clk); #1;
    ascii_valid = 1'b0;
    repeat (138) @(posedge clk);
    #1 check("midframe_busy", {31'd0, busy}, 32'd1);
    check("midframe_remaining", exp_q0.size(), 2);
    rst_n = 1'b0;
    #1;
    check("abort_lines", {30'd0, ps2_clk, ps2_data}, 32'd3);
    check("abort_ready", {31'd0, ascii_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    exp_q0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_key(0, 8'h5a, 8'h1a, 312);

    // Minimum timing parameters.
    send_key(1, 8'h2e, 8'h49, 69);

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q0.size(), 0);
    check("queue_empty_fast", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
